// File: rtl/trdb_branch_map.sv
// trdb_branch_map
// Records the taken/not-taken outcome of every retired conditional branch in
// a shift-style map (oldest branch in bit 0, stored bit = 1 for not taken).
// Reports empty/full status to the packet-format selector and hands a
// registered snapshot of the map and its entry count to the packet emitter
// whenever a packet consumes the map (flush_i).
//
// Ports:
//   clk_i          - clock, all logic on the rising edge
//   rst_i          - synchronous active-high reset
//   valid_i        - retire interface carries a valid instruction
//   branch_i       - retired instruction is a conditional branch
//   branch_taken_i - branch outcome, 1 = taken
//   flush_i        - emitter consumes the map this cycle
//   empty_o        - registered, entry count == 0
//   full_o         - registered, entry count == MAX_BRANCHES
//   count_o        - registered current entry count
//   snap_valid_o   - one-cycle pulse, snapshot fields valid
//   snap_map_o     - snapshot map, unused bits 0
//   snap_count_o   - number of valid bits in snap_map_o
//   overflow_o     - sticky dropped-branch flag (only with TRDB_BRANCH_MAP_ERR_EN)
//
// Optional feature macro: TRDB_BRANCH_MAP_ERR_EN adds overflow_o and its
// sticky register. Without it, records at full capacity are silently dropped.

module trdb_branch_map #(
    parameter int unsigned MAX_BRANCHES = 31,
    parameter int unsigned CNT_W        = $clog2(MAX_BRANCHES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    branch_i,
    input  logic                    branch_taken_i,
    input  logic                    flush_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [CNT_W-1:0]        count_o,
    output logic                    snap_valid_o,
    output logic [MAX_BRANCHES-1:0] snap_map_o,
    output logic [CNT_W-1:0]        snap_count_o
`ifdef TRDB_BRANCH_MAP_ERR_EN
    ,
    output logic                    overflow_o
`endif
);

    logic [MAX_BRANCHES-1:0] map_r;
    logic [CNT_W-1:0]        count_r;
    logic                    empty_r;
    logic                    full_r;
    logic                    snap_valid_r;
    logic [MAX_BRANCHES-1:0] snap_map_r;
    logic [CNT_W-1:0]        snap_count_r;

    logic                    record_s;
    logic                    bit_s;
    logic                    at_cap_s;
    logic [MAX_BRANCHES-1:0] map_app_s;
    logic [MAX_BRANCHES-1:0] map_nxt_s;
    logic [CNT_W-1:0]        count_nxt_s;
    logic [MAX_BRANCHES-1:0] snap_map_nxt_s;
    logic [CNT_W-1:0]        snap_count_nxt_s;

    // Next-state computation for the map, count and snapshot contents.
    always_comb begin
        record_s         = valid_i & branch_i;
        bit_s            = ~branch_taken_i;
        at_cap_s         = (count_r == CNT_W'(MAX_BRANCHES));
        map_nxt_s        = map_r;
        count_nxt_s      = count_r;
        snap_map_nxt_s   = snap_map_r;
        snap_count_nxt_s = snap_count_r;

        // Map with the new bit written at index count; at capacity no index
        // matches, so the map is returned unchanged.
        map_app_s = map_r;
        for (int i = 0; i < int'(MAX_BRANCHES); i++) begin
            if (CNT_W'(i) == count_r) begin
                map_app_s[i] = bit_s;
            end else begin
                map_app_s[i] = map_r[i];
            end
        end

        if (flush_i) begin
            if (record_s && !at_cap_s) begin
                // New branch is appended first and travels in this snapshot.
                snap_map_nxt_s   = map_app_s;
                snap_count_nxt_s = count_r + CNT_W'(1);
                map_nxt_s        = '0;
                count_nxt_s      = '0;
            end else if (record_s) begin
                // Full map leaves in the snapshot; new branch starts the next map.
                snap_map_nxt_s   = map_r;
                snap_count_nxt_s = count_r;
                map_nxt_s        = '0;
                map_nxt_s[0]     = bit_s;
                count_nxt_s      = CNT_W'(1);
            end else begin
                snap_map_nxt_s   = map_r;
                snap_count_nxt_s = count_r;
                map_nxt_s        = '0;
                count_nxt_s      = '0;
            end
        end else if (record_s && !at_cap_s) begin
            map_nxt_s   = map_app_s;
            count_nxt_s = count_r + CNT_W'(1);
        end else begin
            // Idle, or a record dropped at capacity: state holds.
            map_nxt_s   = map_r;
            count_nxt_s = count_r;
        end
    end

    // State and registered status/snapshot outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_r        <= '0;
            count_r      <= '0;
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
            snap_valid_r <= 1'b0;
            snap_map_r   <= '0;
            snap_count_r <= '0;
        end else begin
            map_r        <= map_nxt_s;
            count_r      <= count_nxt_s;
            empty_r      <= (count_nxt_s == CNT_W'(0));
            full_r       <= (count_nxt_s == CNT_W'(MAX_BRANCHES));
            snap_valid_r <= flush_i;
            snap_map_r   <= snap_map_nxt_s;
            snap_count_r <= snap_count_nxt_s;
        end
    end

`ifdef TRDB_BRANCH_MAP_ERR_EN
    logic overflow_r;

    // Sticky flag for a record dropped at capacity; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (record_s & at_cap_s & ~flush_i);
        end
    end

    assign overflow_o = overflow_r;
`endif

    assign empty_o      = empty_r;
    assign full_o       = full_r;
    assign count_o      = count_r;
    assign snap_valid_o = snap_valid_r;
    assign snap_map_o   = snap_map_r;
    assign snap_count_o = snap_count_r;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed self-checking bench for trdb_branch_map (default parameters).
module tb_trdb_branch_map;

    localparam int unsigned MAXB = 31;
    localparam int unsigned CW   = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          branch_i;
    logic          branch_taken_i;
    logic          flush_i;
    logic          empty_o;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          snap_valid_o;
    logic [MAXB-1:0] snap_map_o;
    logic [CW-1:0] snap_count_o;
`ifdef TRDB_BRANCH_MAP_ERR_EN
    logic          overflow_o;
`endif

    int checks = 0;
    int errors = 0;

    trdb_branch_map #(.MAX_BRANCHES(MAXB)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .branch_i       (branch_i),
        .branch_taken_i (branch_taken_i),
        .flush_i        (flush_i),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .snap_valid_o   (snap_valid_o),
        .snap_map_o     (snap_map_o),
        .snap_count_o   (snap_count_o)
`ifdef TRDB_BRANCH_MAP_ERR_EN
        ,
        .overflow_o     (overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle 1 time unit past the edge.
    task automatic drive(input logic v, input logic b, input logic t, input logic f, input logic r);
        valid_i        = v;
        branch_i       = b;
        branch_taken_i = t;
        flush_i        = f;
        rst_i          = r;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset, then ten idle cycles at reset values.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("idle_empty", 32'(empty_o), 32'd1);
            check("idle_full", 32'(full_o), 32'd0);
            check("idle_count", 32'(count_o), 32'd0);
            check("idle_snap_valid", 32'(snap_valid_o), 32'd0);
        end
        check("rst_snap_map", 32'(snap_map_o), 32'd0);
        check("rst_snap_count", 32'(snap_count_o), 32'd0);
`ifdef TRDB_BRANCH_MAP_ERR_EN
        check("rst_overflow", 32'(overflow_o), 32'd0);
`endif

        // taken, not-taken, not-taken, then flush -> map 0b110, count 3.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("three_count", 32'(count_o), 32'd3);
        check("three_empty", 32'(empty_o), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("f1_snap_valid", 32'(snap_valid_o), 32'd1);
        check("f1_snap_count", 32'(snap_count_o), 32'd3);
        check("f1_snap_map", 32'(snap_map_o), 32'h6);
        check("f1_count", 32'(count_o), 32'd0);
        check("f1_empty", 32'(empty_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("f1_pulse_end", 32'(snap_valid_o), 32'd0);
        check("f1_map_hold", 32'(snap_map_o), 32'h6);
        check("f1_count_hold", 32'(snap_count_o), 32'd3);

        // Fill 31 not-taken, then record + flush at capacity.
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("fill_full", 32'(full_o), 32'd1);
        check("fill_count", 32'(count_o), 32'd31);
        check("fill_empty", 32'(empty_o), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("capf_snap_valid", 32'(snap_valid_o), 32'd1);
        check("capf_snap_count", 32'(snap_count_o), 32'd31);
        check("capf_snap_map", 32'(snap_map_o), 32'h7FFF_FFFF);
        check("capf_count", 32'(count_o), 32'd1);
        check("capf_full", 32'(full_o), 32'd0);
        // Back-to-back flushes: carried-over bit, then an empty snapshot.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("carry_snap_valid", 32'(snap_valid_o), 32'd1);
        check("carry_snap_count", 32'(snap_count_o), 32'd1);
        check("carry_snap_map", 32'(snap_map_o), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("emptyf_snap_valid", 32'(snap_valid_o), 32'd1);
        check("emptyf_snap_count", 32'(snap_count_o), 32'd0);
        check("emptyf_snap_map", 32'(snap_map_o), 32'h0);

        // valid_i low: branch ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("novalid_count", 32'(count_o), 32'd0);
        check("novalid_snap_valid", 32'(snap_valid_o), 32'd0);

        // Fill, then a taken record without flush is dropped.
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("drop_count", 32'(count_o), 32'd31);
        check("drop_full", 32'(full_o), 32'd1);
`ifdef TRDB_BRANCH_MAP_ERR_EN
        check("drop_overflow", 32'(overflow_o), 32'd1);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drop_snap_count", 32'(snap_count_o), 32'd31);
        check("drop_snap_map", 32'(snap_map_o), 32'h7FFF_FFFF);
        check("drop_after_count", 32'(count_o), 32'd0);
`ifdef TRDB_BRANCH_MAP_ERR_EN
        check("overflow_sticky", 32'(overflow_o), 32'd1);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst2_snap_map", 32'(snap_map_o), 32'd0);
        check("rst2_snap_count", 32'(snap_count_o), 32'd0);
`ifdef TRDB_BRANCH_MAP_ERR_EN
        check("rst2_overflow", 32'(overflow_o), 32'd0);
`endif

        // count=2 (map 0b01), then taken record + flush -> 3 entries, bit2 = 0.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("two_count", 32'(count_o), 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("recf_snap_valid", 32'(snap_valid_o), 32'd1);
        check("recf_snap_count", 32'(snap_count_o), 32'd3);
        check("recf_snap_map", 32'(snap_map_o), 32'h1);
        check("recf_count", 32'(count_o), 32'd0);
        check("recf_empty", 32'(empty_o), 32'd1);

        // Five records, then flush in the reset cycle -> no snapshot.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("five_count", 32'(count_o), 32'd5);
        check("five_snap_hold", 32'(snap_count_o), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rstf_snap_valid", 32'(snap_valid_o), 32'd0);
        check("rstf_snap_map", 32'(snap_map_o), 32'd0);
        check("rstf_snap_count", 32'(snap_count_o), 32'd0);
        check("rstf_count", 32'(count_o), 32'd0);
        check("rstf_empty", 32'(empty_o), 32'd1);
        check("rstf_full", 32'(full_o), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_snap_valid", 32'(snap_valid_o), 32'd0);
        check("post_rst_count", 32'(count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map.md
# trdb_branch_map

Records the taken/not-taken outcome of every retired conditional branch in a shift-style map of up to 31 entries. Drives the branch-map empty/full status into the packet-format selector and hands a registered snapshot of the map and branch count to the packet emitter whenever a packet consumes the map. Sits between the instruction-retire interface and the format selector/emitter, as a sibling input stage of the lc/tc/nc pipeline.

## Interface
Parameters:
- MAX_BRANCHES, 31: map capacity in entries; legal range 1..31.
- CNT_W, $clog2(MAX_BRANCHES+1): width of the count fields (5 at default).

Ports:
- clk_i  in  1  clock; single clock domain, all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  retire interface carries a valid instruction this cycle.
- branch_i  in  1  retired instruction is a conditional branch.
- branch_taken_i  in  1  outcome of that branch; 1 = taken.
- flush_i  in  1  emitter consumes the map this cycle (format 0/1/2/3 packet issued).
- empty_o  out  1  registered; count == 0.
- full_o  out  1  registered; count == MAX_BRANCHES.
- count_o  out  CNT_W  registered current entry count.
- snap_valid_o  out  1  one-cycle pulse: snapshot fields valid.
- snap_map_o  out  MAX_BRANCHES  snapshot map; bit i = branch i, oldest in bit 0; unused bits 0.
- snap_count_o  out  CNT_W  number of valid bits in snap_map_o.
- overflow_o  out  1  sticky overflow flag; present only with TRDB_BRANCH_MAP_ERR_EN.

## Operation
- Branch record = valid_i && branch_i. Stored bit = ~branch_taken_i (1 = not taken, per E-trace encoding).
- Record with count < MAX_BRANCHES and no flush: map[count] <= bit; count <= count+1.
- Record at count == MAX_BRANCHES without flush: branch dropped, map/count unchanged; overflow set when enabled. Selector must prevent this by issuing a packet on full.
- flush_i, no record: snapshot = current map/count; map cleared to 0, count <= 0.
- flush_i with record and count < MAX_BRANCHES: record appended first; snapshot includes it (count+1 entries); map then cleared, count <= 0.
- flush_i with record and count == MAX_BRANCHES: snapshot = existing MAX_BRANCHES entries; new bit becomes map[0], count <= 1.
- flush_i with count == 0 and no record: snap_valid_o still pulses, snap_count_o = 0, snap_map_o = 0.
- valid_i low: branch_i/branch_taken_i ignored; flush_i still honoured.
- Map bits at index >= count are always 0.
- Reset (any cycle, including the cycle of a flush or record): map, count, snapshot regs, snap_valid_o and overflow cleared; no snapshot produced for a flush in the reset cycle.
- Outputs at reset: empty_o = 1, full_o = 0, count_o = 0, snap_valid_o = 0, snap_map_o = 0, snap_count_o = 0, overflow_o = 0.

## Timing
- Event in cycle N (record/flush) -> count_o, empty_o, full_o updated in cycle N+1.
- Snapshot: flush_i in cycle N -> snap_valid_o = 1 with snap_map_o/snap_count_o in cycle N+1, for exactly one cycle; snapshot fields hold until the next flush.
- Back-to-back flushes produce back-to-back snap_valid_o pulses, each with its own contents.
- No backpressure: emitter must sample the snapshot in the pulse cycle.
- full_o rises in the cycle after the MAX_BRANCHES-th record; one cycle is available for the selector to assert flush_i before a further branch would overflow.

## Configuration
- TRDB_BRANCH_MAP_ERR_EN defined: overflow_o port present; set on a dropped record, cleared only by rst_i.
- Not defined: port absent, no overflow register; dropped records are silently discarded, all other behaviour identical.

## Test plan
- Reset release, no stimulus -> empty_o = 1, full_o = 0, count_o = 0, snap_valid_o = 0 for 10 cycles.
- Records taken, not-taken, not-taken, then flush -> next cycle snap_count_o = 3, snap_map_o = 0b110, snap_valid_o one pulse; count_o = 0.
- 31 records, all not-taken -> full_o = 1, count_o = 31; 32nd record with flush -> snap_count_o = 31, snap_map_o = 0x7FFFFFFF, then count_o = 1, map[0] = 1.
- 32nd record without flush (macro on) -> count_o stays 31, overflow_o = 1 and held until rst_i.
- Record (taken) and flush same cycle at count = 2 -> snap_count_o = 3, bit 2 = 0; count_o = 0, empty_o = 1.
- Flush with count = 5 in the same cycle as rst_i -> no snap_valid_o pulse; all outputs at reset values next cycle.
